// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter.
// Turns a raw request vector into a held one-hot grant. Priority rotates
// through a mask of the bits strictly above the last winner. If no masked
// request is pending, an unmasked lowest-bit scan is the fallback. An
// optional hold limit forces the current owner to give way to waiting
// requesters.
module rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 0,
    parameter int IDW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic [IDW-1:0]   grant_id,
    output logic             grant_valid,
    output logic             preempt
);

    // With preemption disabled the counter is irrelevant, so it only needs to reach 1.
    localparam int HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
    localparam int CW       = $clog2(HOLD_SAT + 1);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);
    localparam logic [CW-1:0]    CNT_SAT = CW'(HOLD_SAT);
    localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    // The holder's bit is removed before selection. A release, a timeout and
    // an idle start can therefore share one winner computation.
    logic [WIDTH-1:0] others;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] win;
    logic [WIDTH-1:0] win_above;
    logic [IDW-1:0]   win_id;
    logic             holder_req;
    logic             any_other;
    logic             timeout;

    assign others     = req & ~grant_q;
    assign cand       = others & mask_q;
    assign win        = (|cand) ? (cand & (~cand + ONE)) : (others & (~others + ONE));
    assign win_above  = ~(win | (win - ONE));
    assign holder_req = |(req & grant_q);
    assign any_other  = |others;
    assign timeout    = (MAX_HOLD != 0) && (cnt_q == CNT_MAX) && any_other && holder_req;

    // One-hot to binary: id bit gi is the OR of all winner bits whose index has bit gi set.
    genvar gi, gj;
    generate
        for (gi = 0; gi < IDW; gi++) begin : g_enc
            logic [WIDTH-1:0] sel;
            for (gj = 0; gj < WIDTH; gj++) begin : g_bit
                if (((gj >> gi) & 1) == 1) begin : g_on
                    assign sel[gj] = win[gj];
                end else begin : g_off
                    assign sel[gj] = 1'b0;
                end
            end
            assign win_id[gi] = |sel;
        end
    endgenerate

    // State register: all arbiter state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            mask_q    <= '1;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    // Next-state logic: new grant on idle start, release or timeout; otherwise hold.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    grant_d = win;
                    id_d    = win_id;
                    mask_d  = win_above;
                    cnt_d   = CNT_ONE;
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    // Release takes precedence over a coincident timeout.
                    if (any_other) begin
                        grant_d = win;
                        id_d    = win_id;
                        mask_d  = win_above;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        id_d    = '0;
                        cnt_d   = '0;
                    end
                end else if (timeout) begin
                    grant_d   = win;
                    id_d      = win_id;
                    mask_d    = win_above;
                    cnt_d     = CNT_ONE;
                    preempt_d = 1'b1;
                end else if (any_other) begin
                    if (cnt_q < CNT_SAT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        grant       = grant_q;
        grant_id    = id_q;
        grant_valid = |grant_q;
        preempt     = preempt_q;
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter. Two instances share one stimulus:
// one has preemption disabled and one has MAX_HOLD=4. A rotating-scan
// reference model predicts both. The stimulus side queues the predictions.
// A monitor on the falling edge pops them and compares them.
module tb_rr_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] req = '0;

    logic [W-1:0] grant0, grant4;
    logic [2:0]   id0, id4;
    logic         v0, v4, p0, p4;

    rr_arbiter #(.WIDTH(W), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant0), .grant_id(id0), .grant_valid(v0), .preempt(p0)
    );

    rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant4), .grant_id(id4), .grant_valid(v4), .preempt(p4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] g;
        logic [2:0]   id;
        logic         v;
        logic         p;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];

    // Model state per instance. cur is the holder (-1 means idle). last is the
    // most recent winner (-1 after reset). The scan restarts just above last.
    int cur[2];
    int last[2];
    int cnt[2];
    bit pre[2];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int pick(input int m, input logic [W-1:0] r);
        for (int i = last[m] + 1; i < W; i++) if (r[i]) return i;
        for (int i = 0; i < W; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic exp_t expect_of(input int m);
        exp_t e;
        e.g  = (cur[m] >= 0) ? (W'(1) << cur[m]) : '0;
        e.id = (cur[m] >= 0) ? 3'(cur[m]) : 3'd0;
        e.v  = (cur[m] >= 0);
        e.p  = pre[m];
        return e;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            cur[m] = -1; last[m] = -1; cnt[m] = 0; pre[m] = 1'b0;
        end
    endtask

    task automatic grant_to(input int m, input int k);
        cur[m] = k; last[m] = k; cnt[m] = 1;
    endtask

    task automatic model_step(input logic [W-1:0] r);
        for (int m = 0; m < 2; m++) begin
            int mh;
            logic [W-1:0] rest;
            mh = (m == 0) ? 0 : 4;
            pre[m] = 1'b0;
            rest = r;
            if (cur[m] >= 0) rest[cur[m]] = 1'b0;
            if (cur[m] < 0) begin
                if (r != '0) grant_to(m, pick(m, r));
            end else if (!r[cur[m]]) begin
                if (rest != '0) grant_to(m, pick(m, rest));
                else begin cur[m] = -1; cnt[m] = 0; end
            end else if (mh != 0 && cnt[m] == mh && rest != '0) begin
                grant_to(m, pick(m, rest));
                pre[m] = 1'b1;
            end else if (rest != '0) begin
                if (mh == 0 || cnt[m] < mh) cnt[m]++;
            end else begin
                cnt[m] = 1;
            end
        end
        q0.push_back(expect_of(0));
        q4.push_back(expect_of(1));
    endtask

    // Apply a request vector for one clock edge and queue the predicted outputs.
    task automatic cyc(input logic [W-1:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #2;
    endtask

    // Pulse reset between edges. The outputs must clear without a clock.
    task automatic reset_pulse();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst grant0", 32'(grant0), 32'h0);
        chk("async_rst valid0", 32'(v0), 32'h0);
        chk("async_rst grant4", 32'(grant4), 32'h0);
        chk("async_rst valid4", 32'(v4), 32'h0);
        chk("async_rst preempt4", 32'(p4), 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    task automatic compare_one(input string tag, input exp_t e, input logic [W-1:0] g,
                               input logic [2:0] id, input logic v, input logic p);
        chk({tag, " grant"}, 32'(g), 32'(e.g));
        chk({tag, " valid"}, 32'(v), 32'(e.v));
        chk({tag, " preempt"}, 32'(p), 32'(e.p));
        if (e.v) chk({tag, " grant_id"}, 32'(id), 32'(e.id));
    endtask

    // Monitor: registered outputs are stable at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q0.size() > 0) compare_one("sb d0", q0.pop_front(), grant0, id0, v0, p0);
            if (q4.size() > 0) compare_one("sb d4", q4.pop_front(), grant4, id4, v4, p4);
        end
    end

    initial begin
        logic [W-1:0] r;
        r = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("reset grant0", 32'(grant0), 32'h0);
        chk("reset id0", 32'(id0), 32'h0);
        chk("reset valid0", 32'(v0), 32'h0);
        chk("reset preempt0", 32'(p0), 32'h0);
        chk("reset grant4", 32'(grant4), 32'h0);
        chk("reset id4", 32'(id4), 32'h0);
        chk("reset valid4", 32'(v4), 32'h0);
        chk("reset preempt4", 32'(p4), 32'h0);
        rst_n = 1'b1;

        // Basic single request
        cyc(8'b0000_0100);
        chk("basic grant", 32'(grant4), 32'h04);
        chk("basic id", 32'(id4), 32'd2);
        chk("basic valid", 32'(v4), 32'd1);
        cyc(8'b0000_0000);
        chk("basic release grant", 32'(grant4), 32'h00);
        chk("basic release valid", 32'(v4), 32'd0);

        // Rotation fairness: 0 -> 2 -> 7 -> 0 with no bubble
        reset_pulse();
        cyc(8'b1000_0101); chk("rot step0", 32'(grant0), 32'h01);
        cyc(8'b1000_0100); chk("rot step1", 32'(grant0), 32'h04);
        cyc(8'b1000_0001); chk("rot step2", 32'(grant0), 32'h80);
        cyc(8'b0000_0101); chk("rot step3", 32'(grant0), 32'h01);

        // Lock hold with preemption disabled
        reset_pulse();
        for (int c = 0; c < 10; c++) begin
            cyc(8'b0000_0011);
            chk("lock hold", 32'(grant0), 32'h01);
        end
        cyc(8'b0000_0010);
        chk("lock handoff", 32'(grant0), 32'h02);

        // Timeout preemption with MAX_HOLD=4
        reset_pulse();
        for (int c = 1; c <= 9; c++) begin
            cyc(8'b0001_0001);
            chk("timeout grant", 32'(grant4), (c <= 4 || c == 9) ? 32'h01 : 32'h10);
            chk("timeout preempt", 32'(p4), (c == 5 || c == 9) ? 32'd1 : 32'd0);
        end

        // Wrap: after bit 7 the mask is empty and the fallback starts at bit 0
        reset_pulse();
        cyc(8'b1000_0000); chk("wrap first", 32'(grant0), 32'h80);
        cyc(8'b0000_0000);
        cyc(8'b1000_0010); chk("wrap fallback", 32'(grant0), 32'h02);

        // Asynchronous reset in the middle of a grant
        reset_pulse();
        cyc(8'b0000_1000); chk("midrst before", 32'(grant4), 32'h08);
        reset_pulse();
        cyc(8'b0000_1001); chk("midrst after", 32'(grant4), 32'h01);

        // Randomized traffic: slowly changing requests, with occasional drops and resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 249) == 0) reset_pulse();
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(0, 39) == 0) r = '0;
            cyc(r);
        end

        @(negedge clk);
        #1;
        chk("scoreboard drained d0", 32'(q0.size()), 32'd0);
        chk("scoreboard drained d4", 32'(q4.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Registered round-robin arbiter. It turns a raw multi-bit request vector into a held, one-hot grant.
- Internally it uses two lowest-set-bit scans: one over a masked request vector (rotating priority) and one over the unmasked vector (fallback).
- It sits directly downstream of the requesters, ahead of any shared resource (bus, memory port, FIFO write side).
- Adds grant locking, fair rotation and an optional hold-timeout preemption on top of pure combinational priority selection.

Parameters:
- WIDTH, 8, number of requesters (>=2).
- MAX_HOLD, 0, max consecutive cycles one requester may hold the grant while any other request is pending; 0 disables preemption.
- IDW, $clog2(WIDTH), width of grant_id (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  WIDTH  request vector; requester i holds req[i] high for as long as it needs the resource.
- grant  output  WIDTH  registered one-hot grant; all-zero when idle.
- grant_id  output  IDW  binary index of the granted requester; valid only when grant_valid=1.
- grant_valid  output  1  high iff grant is non-zero.
- preempt  output  1  one-cycle pulse, high in the first cycle after a grant was revoked by timeout.

Behaviour:
- Reset (async assert, sync-safe deassert to first clk edge):
  - grant=0, grant_id=0, grant_valid=0, preempt=0.
  - State=IDLE, hold counter=0.
  - Priority mask=all ones, so bit 0 has top priority.
- Winner selection (combinational):
  - cand = req & mask. The mask always excludes the requester currently holding the grant.
  - win = lowest set bit of cand if cand!=0, else lowest set bit of req.
  - win=0 when req=0.
- Mask update: on every new grant to index k, mask <= bits strictly above k. For k=WIDTH-1 the mask becomes 0, and the fallback scan then restarts from bit 0.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, at the next edge: grant<=win, grant_id<=index(win), grant_valid<=1, hold counter<=1, go to GRANT.
  - Latency is exactly 1 cycle from req sampled high to grant high.
  - If req==0, stay in IDLE with outputs 0.
- GRANT, release: req[grant_id]==0 at an edge.
  - Re-arbitrate in that same edge using the current req; the released bit is already 0.
  - If another requester is pending: grant moves to the new winner with no bubble, counter<=1.
  - Else: grant<=0, go to IDLE.
- GRANT, hold: req[grant_id]==1 and no timeout. Grant unchanged. The counter increments while any other req bit is set, saturates at MAX_HOLD, and resets to 1 when no other request is pending.
- GRANT, timeout: MAX_HOLD!=0, counter==MAX_HOLD, another req pending.
  - At the edge: grant moves to win computed over req with the current holder's bit cleared.
  - preempt<=1 for exactly one cycle. mask is updated as for a normal grant and the counter reloads to 1.
  - The preempted requester may keep req high; it re-competes in normal rotation.
- Simultaneous events:
  - Release and timeout in the same cycle: treated as a release; preempt stays 0.
  - New requests arriving while locked do not disturb the current grant.
- Invariants:
  - grant is always one-hot or zero.
  - grant is only ever set on a bit whose req was 1 at the selecting edge.
  - grant never changes except at a release, a timeout, or reset.
- Reset mid-grant: outputs clear immediately (asynchronous). After release of reset, arbitration restarts from bit 0 priority.
- A requester that drops req without having been granted is simply never selected. No state is kept per requester other than the mask.

Test Plan:
- Basic single request: reset, then req=8'b0000_0100 → after 1 clk, grant=8'b0000_0100, grant_id=2, grant_valid=1. Drop req → next clk grant=0, grant_valid=0.
- Rotation fairness: req=8'b1000_0101 held, each owner drops its bit for one cycle after being granted. The grant sequence must be bit0 → bit2 → bit7 → bit0, with no idle cycle between grants.
- Lock hold: req=8'b0000_0011 with bit0 held for 10 cycles, MAX_HOLD=0 → grant stays 8'b0000_0001 for all 10 cycles. On bit0 drop → next clk grant=8'b0000_0010.
- Timeout preemption: MAX_HOLD=4, req=8'b0001_0001 both held. Grant=bit0 for exactly 4 cycles, then grant=8'b0001_0000 with preempt=1 for one cycle. Four cycles later grant returns to bit0.
- Wrap and mask-zero: grant bit7 first (req=8'b1000_0000), then req=8'b1000_0010 after release → grant=8'b0000_0010, proving the mask=0 fallback.
- Async reset mid-grant: while grant=8'b0000_1000, pulse rst_n low between edges → grant=0, grant_valid=0 immediately. After release with req=8'b0000_1001 → grant=8'b0000_0001.
